pc_fetch: RTL and testbench

//   Owns the program-counter register and the instruction-fetch handshake for the Redux-V core.
//   - Drives cur_pc into next_pc and takes n_pc back at the end of each instruction.
//   - Fetches the byte at cur_pc from instruction memory with a req/ack handshake.
//   - Presents the byte to decode/execute and waits for exec_done before advancing.

---
 rtl/redux_pkg.sv | 18 +
 rtl/pc_fetch_if.sv | 32 +++
 rtl/pc_fetch_timer.sv | 34 +++
 rtl/pc_fetch.sv | 165 ++++++++++++++++
 tb/tb_pc_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/redux_pkg.sv
// redux_pkg: shared definitions for the Redux-V fetch unit.
//   - REDUX_DATA_W / REDUX_RESET_PC / REDUX_MAX_WAIT : default widths and reset values
//   - state_t : fetch FSM state encoding (S_IDLE, S_REQ, S_EXEC, S_UPD, S_HALT)
package redux_pkg;

   localparam int REDUX_DATA_W   = 8;
   localparam int REDUX_RESET_PC = 0;
   localparam int REDUX_MAX_WAIT = 15;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_EXEC = 3'd2,
      S_UPD  = 3'd3,
      S_HALT = 3'd4
   } state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory and decode/execute handshake of the fetch unit.
//   master (pc_fetch): drives imem_req, imem_addr, instr, instr_valid;
//                      receives imem_ack, imem_data, exec_done, n_pc, jmx, bmx.
//   slave  (memory / execute side): the opposite directions.
interface pc_fetch_if
   import redux_pkg::*;
#(
   parameter int DATA_W = REDUX_DATA_W
) ();

   logic              imem_req;
   logic [DATA_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_data;
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              exec_done;
   logic [DATA_W-1:0] n_pc;
   logic              jmx;
   logic              bmx;

   modport master (
      output imem_req, imem_addr, instr, instr_valid,
      input  imem_ack, imem_data, exec_done, n_pc, jmx, bmx
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid,
      output imem_ack, imem_data, exec_done, n_pc, jmx, bmx
   );

endinterface

// File: rtl/pc_fetch_timer.sv
// fetch_timer: saturating wait counter for the imem handshake.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : return the count to zero (has priority over inc)
//   inc      : advance the count by one, saturating at all-ones
//   expired  : count has reached MAX_WAIT-1
module fetch_timer #(
   parameter int CNT_W    = 8,
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   logic [CNT_W-1:0] cnt_r;

   // Wait counter: clear wins, increment stops at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = (cnt_r == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program-counter register and instruction-fetch sequencer of Redux-V.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : leave IDLE and fetch at cur_pc
//   halt_req          : return to IDLE after the current instruction retires
//   bus (master)      : imem req/ack fetch and instr/exec_done decode handshake
//   cur_pc            : current PC
//   running           : high in REQ/EXEC/UPD
//   fetch_err         : sticky imem_ack timeout
//   wrap_err          : sticky sequential PC wrap
// Optional feature: define REDUX_PC_WRAP_TRAP_EN to halt on a sequential
// wrap from all-ones to zero; otherwise the PC wraps silently and wrap_err is 0.
module pc_fetch
   import redux_pkg::*;
#(
   parameter int                DATA_W   = REDUX_DATA_W,
   parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(REDUX_RESET_PC),
   parameter int                MAX_WAIT = REDUX_MAX_WAIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt_req,
   pc_fetch_if.master        bus,
   output logic [DATA_W-1:0] cur_pc,
   output logic              running,
   output logic              fetch_err,
   output logic              wrap_err
);

`ifdef REDUX_PC_WRAP_TRAP_EN
   localparam logic WRAP_TRAP = 1'b1;
`else
   localparam logic WRAP_TRAP = 1'b0;
`endif

   // Fall-through from all-ones to zero; jumps and branches to zero are legal.
   function automatic logic seq_wrap(input logic [DATA_W-1:0] pc,
                                     input logic [DATA_W-1:0] npc,
                                     input logic              j,
                                     input logic              b);
      return (pc == {DATA_W{1'b1}}) && (npc == {DATA_W{1'b0}}) && !j && !b;
   endfunction

   state_t            state_r;
   logic [DATA_W-1:0] cur_pc_r;
   logic [DATA_W-1:0] instr_r;
   logic              imem_req_r;
   logic              instr_valid_r;
   logic              running_r;
   logic              fetch_err_r;
   logic              wrap_err_r;

   logic              timer_clr_s;
   logic              timer_inc_s;
   logic              timer_expired_s;
   logic              wrap_trap_s;

   assign wrap_trap_s = WRAP_TRAP & seq_wrap(cur_pc_r, bus.n_pc, bus.jmx, bus.bmx);

   // Timer counts only unanswered REQ cycles and sits at zero elsewhere.
   always_comb begin
      timer_clr_s = 1'b1;
      timer_inc_s = 1'b0;
      if (state_r == S_REQ) begin
         if (bus.imem_ack || timer_expired_s) begin
            timer_clr_s = 1'b1;
            timer_inc_s = 1'b0;
         end else begin
            timer_clr_s = 1'b0;
            timer_inc_s = 1'b1;
         end
      end else begin
         timer_clr_s = 1'b1;
         timer_inc_s = 1'b0;
      end
   end

   fetch_timer #(
      .CNT_W    (8),
      .MAX_WAIT (MAX_WAIT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (timer_clr_s),
      .inc     (timer_inc_s),
      .expired (timer_expired_s)
   );

   // Fetch FSM; outputs are set together with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= S_IDLE;
         cur_pc_r      <= RESET_PC;
         instr_r       <= {DATA_W{1'b0}};
         imem_req_r    <= 1'b0;
         instr_valid_r <= 1'b0;
         running_r     <= 1'b0;
         fetch_err_r   <= 1'b0;
         wrap_err_r    <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  state_r    <= S_REQ;
                  imem_req_r <= 1'b1;
                  running_r  <= 1'b1;
               end
            end
            S_REQ: begin
               if (bus.imem_ack) begin
                  instr_r       <= bus.imem_data;
                  state_r       <= S_EXEC;
                  imem_req_r    <= 1'b0;
                  instr_valid_r <= 1'b1;
               end else if (timer_expired_s) begin
                  fetch_err_r <= 1'b1;
                  state_r     <= S_HALT;
                  imem_req_r  <= 1'b0;
                  running_r   <= 1'b0;
               end
            end
            S_EXEC: begin
               if (bus.exec_done) begin
                  state_r       <= S_UPD;
                  instr_valid_r <= 1'b0;
               end
            end
            S_UPD: begin
               cur_pc_r <= bus.n_pc;
               if (wrap_trap_s) begin
                  wrap_err_r <= 1'b1;
                  state_r    <= S_HALT;
                  running_r  <= 1'b0;
               end else if (halt_req) begin
                  state_r   <= S_IDLE;
                  running_r <= 1'b0;
               end else begin
                  state_r    <= S_REQ;
                  imem_req_r <= 1'b1;
               end
            end
            S_HALT: begin
               state_r <= S_HALT;
            end
            default: begin
               // Unknown encoding: park quietly in HALT.
               state_r       <= S_HALT;
               imem_req_r    <= 1'b0;
               instr_valid_r <= 1'b0;
               running_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = imem_req_r;
   assign bus.imem_addr   = cur_pc_r;
   assign bus.instr       = instr_r;
   assign bus.instr_valid = instr_valid_r;
   assign cur_pc          = cur_pc_r;
   assign running         = running_r;
   assign fetch_err       = fetch_err_r;
   assign wrap_err        = wrap_err_r;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized scoreboard bench for pc_fetch (DATA_W=8, RESET_PC=0, MAX_WAIT=15).
// The stimulus process acts as instruction memory and execute stage, tracks the
// architectural PC in a reference variable and queues the expected fetch address
// and fetched byte; a monitor compares them when imem_req / instr_valid rise.
module tb_pc_fetch;

`ifdef REDUX_PC_WRAP_TRAP_EN
   localparam logic WRAP_TRAP = 1'b1;
`else
   localparam logic WRAP_TRAP = 1'b0;
`endif

   typedef struct {
      logic [7:0] pc;
      logic [7:0] data;
   } fetch_exp_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic       halt_req;
   logic [7:0] cur_pc;
   logic       running;
   logic       fetch_err;
   logic       wrap_err;

   pc_fetch_if #(.DATA_W(8)) bus ();

   pc_fetch #(
      .DATA_W   (8),
      .RESET_PC (8'd0),
      .MAX_WAIT (15)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .halt_req  (halt_req),
      .bus       (bus),
      .cur_pc    (cur_pc),
      .running   (running),
      .fetch_err (fetch_err),
      .wrap_err  (wrap_err)
   );

   int         n_cmp;
   int         n_bad;
   int         cyc;
   int         rise_cyc;
   int         prev_rise_cyc;
   logic [7:0] model_pc;
   logic       model_run;
   logic [7:0] addr_q[$];
   fetch_exp_t data_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_start();
      addr_q.push_back(model_pc);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      addr_q.delete();
      data_q.delete();
      model_pc = 8'd0;
      tick();
   endtask

   // Memory side: lat unanswered REQ cycles (with stray exec_done/start), then ack.
   task automatic fetch(input logic [7:0] d, input int lat);
      for (int k = 0; k < lat; k++) begin
         check("req_wait_imem_req", {31'b0, bus.imem_req}, 32'd1);
         bus.exec_done = 1'($urandom_range(0, 1));
         start         = 1'($urandom_range(0, 1));
         tick();
      end
      bus.exec_done = 1'b0;
      start         = 1'b0;
      check("req_imem_req", {31'b0, bus.imem_req}, 32'd1);
      bus.imem_ack  = 1'b1;
      bus.imem_data = d;
      data_q.push_back('{pc: model_pc, data: d});
      tick();
      bus.imem_ack  = 1'b0;
      bus.imem_data = 8'($urandom);
   endtask

   // Execute side: lat busy EXEC cycles, then exec_done with n_pc/jmx/bmx.
   task automatic execute(input int lat, input logic [7:0] npc, input logic j,
                          input logic b, input logic h);
      logic trap;
      logic cont;
      halt_req = h;
      for (int k = 0; k < lat; k++) begin
         check("exec_instr_valid", {31'b0, bus.instr_valid}, 32'd1);
         start = 1'($urandom_range(0, 1));
         tick();
      end
      start = 1'b0;
      check("exec_instr_valid", {31'b0, bus.instr_valid}, 32'd1);
      trap = WRAP_TRAP && (model_pc == 8'hFF) && (npc == 8'h00) && !j && !b;
      cont = !trap && !h;
      if (cont) addr_q.push_back(npc);
      bus.exec_done = 1'b1;
      bus.n_pc      = npc;
      bus.jmx       = j;
      bus.bmx       = b;
      tick();
      bus.exec_done = 1'b0;
      check("upd_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
      check("upd_running", {31'b0, running}, 32'd1);
      tick();
      halt_req = 1'b0;
      bus.jmx  = 1'b0;
      bus.bmx  = 1'b0;
      bus.n_pc = 8'($urandom);
      model_pc = npc;
      check("cur_pc", {24'b0, cur_pc}, {24'b0, model_pc});
      check("running_after_upd", {31'b0, running}, {31'b0, cont});
      check("imem_req_after_upd", {31'b0, bus.imem_req}, {31'b0, cont});
      check("wrap_err", {31'b0, wrap_err}, {31'b0, trap});
   endtask

   initial begin
      logic [7:0] npc;
      logic       j;
      logic       b;
      logic       h;
      int         r;
      n_cmp = 0; n_bad = 0;
      rise_cyc = 0; prev_rise_cyc = 0;
      rst = 1'b1; start = 1'b0; halt_req = 1'b0;
      bus.imem_ack = 1'b0; bus.imem_data = 8'h00; bus.exec_done = 1'b0;
      bus.n_pc = 8'h00; bus.jmx = 1'b0; bus.bmx = 1'b0;
      model_pc = 8'd0; model_run = 1'b0;

      // Monitor: scoreboard pops on each new fetch request and each new instruction.
      fork
         begin
            logic       prev_req;
            logic       prev_valid;
            logic [7:0] ea;
            fetch_exp_t ed;
            prev_req = 1'b0; prev_valid = 1'b0;
            forever begin
               @(negedge clk);
               if (!rst) begin
                  if (bus.imem_req && !prev_req) begin
                     prev_rise_cyc = rise_cyc;
                     rise_cyc      = cyc;
                     if (addr_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_req: addr %0h with no fetch expected", bus.imem_addr);
                     end else begin
                        ea = addr_q.pop_front();
                        check("imem_addr", {24'b0, bus.imem_addr}, {24'b0, ea});
                     end
                  end
                  if (bus.instr_valid && !prev_valid) begin
                     if (data_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_instr: instr %0h with no ack given", bus.instr);
                     end else begin
                        ed = data_q.pop_front();
                        check("instr", {24'b0, bus.instr}, {24'b0, ed.data});
                        check("exec_cur_pc", {24'b0, cur_pc}, {24'b0, ed.pc});
                     end
                  end
                  check("req_valid_excl", {31'b0, bus.imem_req & bus.instr_valid}, 32'd0);
               end
               prev_req   = bus.imem_req;
               prev_valid = bus.instr_valid;
            end
         end
      join_none

      // Reset state
      repeat (2) tick();
      check("rst_cur_pc", {24'b0, cur_pc}, 32'd0);
      check("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
      check("rst_running", {31'b0, running}, 32'd0);
      check("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
      check("rst_instr", {24'b0, bus.instr}, 32'd0);
      check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
      check("rst_wrap_err", {31'b0, wrap_err}, 32'd0);
      rst = 1'b0;
      tick();
      tick();
      check("idle_quiet", {31'b0, running | bus.imem_req}, 32'd0);

      // Sequential: ack after 2 wait cycles, done in the first EXEC cycle
      do_start();
      check("start_running", {31'b0, running}, 32'd1);
      fetch(8'h5A, 2);
      execute(0, 8'd1, 1'b0, 1'b0, 1'b0);

      // Jump / branch, minimum 3-cycle loop
      fetch(8'($urandom), 0);
      execute(0, 8'd120, 1'b1, 1'b0, 1'b0);
      fetch(8'($urandom), 0);
      execute(0, 8'd126, 1'b1, 1'b0, 1'b0);
      fetch(8'($urandom), 0);
      execute(0, 8'd132, 1'b0, 1'b1, 1'b0);
      fetch(8'($urandom), 0);
      check("loop_cycles", rise_cyc - prev_rise_cyc, 32'd3);

      // Halt: back to IDLE with no request, then restart at the new PC
      execute(1, 8'd8, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("halt_idle_req", {31'b0, bus.imem_req}, 32'd0);
      end
      do_start();
      model_run = 1'b1;

      // Randomized instruction stream
      for (int i = 0; i < 40; i++) begin
         if (!model_run) begin
            do_start();
            model_run = 1'b1;
         end
         fetch(8'($urandom), $urandom_range(0, 5));
         r = $urandom_range(0, 9);
         j = (r >= 5) && (r < 8);
         b = (r >= 8);
         npc = (r < 5) ? model_pc + 8'd1 : 8'($urandom);
         if ((model_pc == 8'hFF) && (npc == 8'h00) && !j && !b) j = 1'b1;
         h = ($urandom_range(0, 9) == 0);
         execute($urandom_range(0, 3), npc, j, b, h);
         model_run = !h;
      end
      if (model_run) begin
         fetch(8'($urandom), 0);
         execute(0, model_pc + 8'd1, 1'b0, 1'b0, 1'b1);
      end

      // Async reset in the middle of REQ
      do_start();
      fetch(8'($urandom), 0);
      execute(0, 8'h33, 1'b1, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      #1;
      check("midreq_cur_pc", {24'b0, cur_pc}, 32'd0);
      check("midreq_imem_req", {31'b0, bus.imem_req}, 32'd0);
      check("midreq_running", {31'b0, running}, 32'd0);
      check("midreq_errors", {30'b0, fetch_err, wrap_err}, 32'd0);
      tick();
      rst = 1'b0;
      addr_q.delete();
      data_q.delete();
      model_pc = 8'd0;
      tick();
      check("midreq_idle", {31'b0, running}, 32'd0);

      // Timeout: 15 REQ cycles without ack
      do_start();
      for (int k = 0; k < 14; k++) tick();
      check("timeout_not_yet", {31'b0, fetch_err}, 32'd0);
      check("timeout_req_held", {31'b0, bus.imem_req}, 32'd1);
      tick();
      check("timeout_fetch_err", {31'b0, fetch_err}, 32'd1);
      check("timeout_imem_req", {31'b0, bus.imem_req}, 32'd0);
      check("timeout_running", {31'b0, running}, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("halt_start_ignored", {31'b0, running | bus.imem_req}, 32'd0);
      check("halt_fetch_err_sticky", {31'b0, fetch_err}, 32'd1);
      do_reset();
      check("reset_clears_fetch_err", {31'b0, fetch_err}, 32'd0);

      // Sequential wrap from 0xFF to 0
      do_start();
      fetch(8'($urandom), 0);
      execute(0, 8'hFF, 1'b1, 1'b0, 1'b0);
      fetch(8'($urandom), 0);
      execute(0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef REDUX_PC_WRAP_TRAP_EN
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("wrap_halt_quiet", {31'b0, running | bus.imem_req}, 32'd0);
      check("wrap_err_sticky", {31'b0, wrap_err}, 32'd1);
`else
      fetch(8'($urandom), 1);
      execute(0, 8'h10, 1'b0, 1'b0, 1'b1);
`endif
      do_reset();

      // Jump / branch to 0 from 0xFF never flags
      do_start();
      fetch(8'($urandom), 0);
      execute(0, 8'hFF, 1'b1, 1'b0, 1'b0);
      fetch(8'($urandom), 0);
      execute(0, 8'h00, 1'b1, 1'b0, 1'b0);
      fetch(8'($urandom), 0);
      execute(0, 8'hFF, 1'b0, 1'b1, 1'b0);
      fetch(8'($urandom), 0);
      execute(0, 8'h00, 1'b0, 1'b1, 1'b0);
      fetch(8'($urandom), 0);
      execute(0, 8'h01, 1'b0, 1'b0, 1'b1);
      tick();
      check("final_queues_empty", addr_q.size() + data_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
